// File: rtl/ethernet_mmio_bridge.sv
// ethernet_mmio_bridge: turns a valid/ready MMIO request/response channel into
// single-cycle register strobes for the Ethernet controller. Handles size and
// alignment checks, write byte-lane steering and read-data extraction, with at
// most one access in flight.
module ethernet_mmio_bridge #(
  parameter  int data_width_p  = 64,
  parameter  int addr_width_p  = 14,
  localparam int bytes_lp      = data_width_p / 8,
  localparam int lg_bytes_lp   = $clog2(bytes_lp),
  localparam int size_width_lp = $clog2(lg_bytes_lp + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic                     req_w_i,
  input  logic [addr_width_p-1:0]  req_addr_i,
  input  logic [size_width_lp-1:0] req_size_i,
  input  logic [data_width_p-1:0]  req_data_i,
  output logic                     resp_v_o,
  input  logic                     resp_ready_i,
  output logic [data_width_p-1:0]  resp_data_o,
  output logic                     resp_err_o,
  output logic [addr_width_p-1:0]  addr_o,
  output logic                     write_en_o,
  output logic                     read_en_o,
  output logic [bytes_lp-1:0]      write_mask_o,
  output logic [data_width_p-1:0]  write_data_o,
  input  logic [data_width_p-1:0]  read_data_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                   state_r;
  logic                     lat_w_r;
  logic [size_width_lp-1:0] lat_size_r;
  logic [lg_bytes_lp-1:0]   lat_low_r;

  int                       req_nbytes;
  int                       req_low;
  logic                     req_bad;
  logic [bytes_lp-1:0]      mask_n;
  logic [data_width_p-1:0]  wdata_n;

  int                       lat_nbytes;
  logic [data_width_p-1:0]  rd_shifted;
  logic [data_width_p-1:0]  rdata_n;

  // Decode the incoming request: alignment check, byte mask and lane-replicated
  // write data. Accesses wider than the data path are rejected like misaligned ones.
  always_comb begin
    req_nbytes = 1 << req_size_i;
    req_low    = int'(req_addr_i[lg_bytes_lp-1:0]);
    req_bad    = ((32'(req_addr_i[lg_bytes_lp-1:0]) & 32'(req_nbytes - 1)) != 32'd0)
                 || (req_nbytes > bytes_lp);
    mask_n     = '0;
    wdata_n    = '0;
    for (int i = 0; i < bytes_lp; i++) begin
      mask_n[i]          = (i >= req_low) && (i < req_low + req_nbytes);
      wdata_n[8*i +: 8]  = req_data_i[8*(i % req_nbytes) +: 8];
    end
  end

  // Shift the addressed bytes of the controller read data down to bit 0 and
  // zero everything above the access size.
  always_comb begin
    lat_nbytes = 1 << lat_size_r;
    rd_shifted = read_data_i >> {lat_low_r, 3'b000};
    rdata_n    = '0;
    for (int i = 0; i < bytes_lp; i++) begin
      rdata_n[8*i +: 8] = (i < lat_nbytes) ? rd_shifted[8*i +: 8] : 8'h00;
    end
  end

  // Transaction FSM; every output is a register so strobes are glitch-free and
  // only high for the single ISSUE cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r      <= IDLE;
      req_ready_o  <= 1'b0;
      resp_v_o     <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_data_o  <= '0;
      addr_o       <= '0;
      write_en_o   <= 1'b0;
      read_en_o    <= 1'b0;
      write_mask_o <= '0;
      write_data_o <= '0;
      lat_w_r      <= 1'b0;
      lat_size_r   <= '0;
      lat_low_r    <= '0;
    end else begin
      write_en_o   <= 1'b0;
      read_en_o    <= 1'b0;
      write_mask_o <= '0;
      case (state_r)
        IDLE: begin
          req_ready_o <= 1'b1;
          if (req_v_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            lat_w_r     <= req_w_i;
            lat_size_r  <= req_size_i;
            lat_low_r   <= req_addr_i[lg_bytes_lp-1:0];
            if (req_bad) begin
              state_r     <= RESP;
              resp_v_o    <= 1'b1;
              resp_err_o  <= 1'b1;
              resp_data_o <= '0;
            end else begin
              state_r      <= ISSUE;
              write_en_o   <= req_w_i;
              read_en_o    <= ~req_w_i;
              addr_o       <= {req_addr_i[addr_width_p-1:lg_bytes_lp], {lg_bytes_lp{1'b0}}};
              write_mask_o <= mask_n;
              write_data_o <= wdata_n;
            end
          end
        end
        ISSUE: begin
          if (lat_w_r) begin
            state_r     <= RESP;
            resp_v_o    <= 1'b1;
            resp_err_o  <= 1'b0;
            resp_data_o <= '0;
          end else begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          state_r     <= RESP;
          resp_v_o    <= 1'b1;
          resp_err_o  <= 1'b0;
          resp_data_o <= rdata_n;
        end
        RESP: begin
          if (resp_ready_i) begin
            state_r     <= IDLE;
            req_ready_o <= 1'b1;
            resp_v_o    <= 1'b0;
            resp_err_o  <= 1'b0;
            resp_data_o <= '0;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ethernet_mmio_bridge.md
Name: ethernet_mmio_bridge

Overview:
- Upstream neighbour of the Ethernet controller wrapper. Converts a valid/ready request/response MMIO channel into the controller's single-cycle register strobes: addr, write_en, read_en, write_mask and write_data, with sync read_data returned one cycle later.
- Performs size/alignment checks, byte-lane steering of write data and read-data extraction.
- Keeps at most one access outstanding.

Parameters:
- data_width_p, 64, controller data width in bits (32 or 64).
- addr_width_p, 14, byte address width presented to the controller.
- size_width_lp (local), `BSG_WIDTH(`BSG_SAFE_CLOG2(data_width_p/8)), size field width; access bytes = 1<<size.

Ports:
- clk_i  in  1  sole clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- req_v_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_w_i  in  1  1=write, 0=read.
- req_addr_i  in  addr_width_p  byte address.
- req_size_i  in  size_width_lp  log2 of access bytes.
- req_data_i  in  data_width_p  write data, LSB-justified.
- resp_v_o  out  1  response valid.
- resp_ready_i  in  1  response ready.
- resp_data_o  out  data_width_p  read data, LSB-justified, zero-extended; 0 for writes and errors.
- resp_err_o  out  1  misaligned request, no access performed.
- addr_o  out  addr_width_p  controller address.
- write_en_o  out  1  controller write strobe.
- read_en_o  out  1  controller read strobe.
- write_mask_o  out  data_width_p/8  byte enables.
- write_data_o  out  data_width_p  lane-replicated write data.
- read_data_i  in  data_width_p  controller sync read data, valid the cycle after read_en_o.

Behaviour:
- Reset (reset_n_i low, async): state=IDLE; req_ready_o, resp_v_o, resp_err_o, write_en_o and read_en_o all 0; addr_o, write_mask_o, write_data_o, resp_data_o all 0.
- req_ready_o is a registered output. It rises on the first clk_i edge after reset release, and thereafter equals (state==IDLE).
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: accept on req_v_i & req_ready_o and latch the request.
    - Misaligned (req_addr_i mod (1<<req_size_i) != 0): go to RESP with err=1; no strobes ever assert.
    - Aligned: go to ISSUE.
  - ISSUE (exactly 1 cycle): write_en_o=req_w or read_en_o=~req_w, driven from registers.
    - addr_o = latched address with the low log2(data_width_p/8) bits cleared.
    - write_mask_o = ((1<<(1<<size))-1) << addr_low.
    - write_data_o = the low (1<<size) bytes of req_data replicated across all lanes.
    - Next state: write -> RESP; read -> WAIT.
  - WAIT (read only, 1 cycle): resp_data register <= (read_data_i >> 8*addr_low), masked to (1<<size) bytes, upper bytes 0. Next state: RESP.
  - RESP: resp_v_o=1. resp_data_o and resp_err_o are stable and held until resp_ready_i. On handshake go to IDLE and clear resp_v_o.
- Strobes and mask are 0 in every state except ISSUE; write_data_o and addr_o may hold their stale values.
- Latency from the accept edge (cycle N):
  - write: strobe in N+1, resp_v_o in N+2;
  - read: strobe in N+1, capture in N+2, resp_v_o in N+3;
  - error: resp_v_o in N+1.
- Minimum request spacing is 3/4/2 cycles (write/read/error) with resp_ready_i tied high.
- resp_ready_i may be held high before resp_v_o rises; that causes no early completion.
- req_* inputs are ignored outside IDLE. The latched request is never modified mid-transaction.
- A full-width access (size = max) at addr_low=0 produces an all-ones mask.
- Address wrap: none; addr_o is the direct latched value.
- Reset asserted mid-transaction (any state) immediately deasserts all strobes and drops resp_v_o. The transaction is lost and no response is produced.

Test Plan:
- 64-bit, write size=0 addr=0x103 data=0xAB, resp_ready=1 -> ISSUE cycle: addr_o=0x100, write_mask_o=0x08, write_data_o=0xABAB_ABAB_ABAB_ABAB, write_en_o pulse 1 cycle; resp_v_o two cycles after accept with resp_err_o=0 and resp_data_o=0.
- Read size=2 addr=0x204, read_data_i=0x1122_3344_5566_7788 in WAIT -> read_en_o 1 cycle with mask 0xF0; resp_data_o=0x0000_0000_1122_3344 at accept+3.
- Write size=3 addr=0x006 -> resp_err_o=1 at accept+1; write_en_o and read_en_o never assert; req_ready_o returns after the response handshake.
- Read with resp_ready_i held low for 5 cycles -> resp_v_o and resp_data_o stable throughout; req_ready_o=0 until handshake; a new req_v_i presented meanwhile is not accepted.
- Back-to-back writes, req_v_i held high, resp_ready=1 -> one accept every 3 cycles; exactly one write_en_o pulse per request.
- reset_n_i pulsed low during ISSUE of a write -> write_en_o drops asynchronously; no resp_v_o; req_ready_o=0 during reset and 1 on the first edge after release.
